// File: rtl/mcu_pkg.sv
// Shared FSM encoding and default build constants for the MCU data-memory controller.
package mcu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } mcu_state_e;

  localparam int         MCU_DATA_W      = 8;
  localparam int         MCU_ADDR_W      = 8;
  localparam logic [7:0] MCU_IO_BASE     = 8'hF0;
  localparam int         MCU_WAIT_STATES = 1;

endpackage

// File: rtl/mcu_sync2.sv
// Two-flop synchroniser for asynchronous input pins; width set by W.
module mcu_sync2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_r;
  logic [W-1:0] sync_r;

  // Capture pins in the first stage, settle in the second
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_r <= '0;
      sync_r <= '0;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/mcu_dmem_ctrl.sv
// Data-memory controller: RAM below IO_BASE, then io_in ports, then io_out registers.
// Build option MCU_IO_SYNC_EN routes io_in through mcu_sync2 before it is read.
module mcu_dmem_ctrl
  import mcu_pkg::*;
#(
  parameter int                DATA_W      = MCU_DATA_W,
  parameter int                ADDR_W      = MCU_ADDR_W,
  parameter logic [ADDR_W-1:0] IO_BASE     = ADDR_W'(MCU_IO_BASE),
  parameter int                N_IN        = 2,
  parameter int                N_OUT       = 2,
  parameter int                WAIT_STATES = MCU_WAIT_STATES
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req,
  input  logic                    we,
  input  logic [ADDR_W-1:0]       addr,
  input  logic [DATA_W-1:0]       wdata,
  output logic [DATA_W-1:0]       rdata,
  output logic                    ack,
  output logic                    err,
  input  logic [N_IN*DATA_W-1:0]  io_in,
  output logic [N_OUT*DATA_W-1:0] io_out
);

  localparam int                RAM_DEPTH = int'(IO_BASE);
  localparam logic [ADDR_W-1:0] OUT_BASE  = IO_BASE + ADDR_W'(N_IN);
  localparam logic [ADDR_W-1:0] MAP_END   = OUT_BASE + ADDR_W'(N_OUT);
  localparam logic [3:0]        WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  mcu_state_e state_r;
  mcu_state_e state_next_s;

  logic [3:0]             wait_cnt_r;
  logic                   we_r;
  logic [ADDR_W-1:0]      addr_r;
  logic [DATA_W-1:0]      wdata_r;
  logic [DATA_W-1:0]      out_r [N_OUT];
  logic [DATA_W-1:0]      mem_r [RAM_DEPTH];
  logic [N_IN*DATA_W-1:0] io_in_s;

  logic                   accept_s;
  logic                   ram_hit_s;
  logic                   in_hit_s;
  logic                   out_hit_s;
  logic                   bad_s;
  logic                   commit_s;
  logic [ADDR_W-1:0]      in_off_s;
  logic [ADDR_W-1:0]      out_off_s;
  logic [DATA_W-1:0]      rd_sel_s;

`ifdef MCU_IO_SYNC_EN
  mcu_sync2 #(
    .W(N_IN*DATA_W)
  ) u_io_sync (
    .clk(clk),
    .rst(rst),
    .d  (io_in),
    .q  (io_in_s)
  );
`else
  assign io_in_s = io_in;
`endif

  // Address decode of the latched access
  always_comb begin
    in_off_s  = addr_r - IO_BASE;
    out_off_s = addr_r - OUT_BASE;
    ram_hit_s = (addr_r < IO_BASE);
    in_hit_s  = (addr_r >= IO_BASE) && (addr_r < OUT_BASE);
    out_hit_s = (addr_r >= OUT_BASE) && (addr_r < MAP_END);
    // Writing a read-only port is treated like an unmapped access
    bad_s     = !(ram_hit_s || in_hit_s || out_hit_s) || (in_hit_s && we_r);
    accept_s  = (state_r == ST_IDLE) && req;
    commit_s  = (state_r == ST_ACK) && we_r && !bad_s;
  end

  // Next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (req) begin
          state_next_s = (WAIT_STATES == 0) ? ST_ACK : ST_WAIT;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (wait_cnt_r == 4'd0) begin
          state_next_s = ST_ACK;
        end else begin
          state_next_s = ST_WAIT;
        end
      end
      ST_ACK:  state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State register, wait counter and request latch
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= ST_IDLE;
      wait_cnt_r <= 4'd0;
      we_r       <= 1'b0;
      addr_r     <= '0;
      wdata_r    <= '0;
    end else begin
      state_r <= state_next_s;
      if (accept_s) begin
        wait_cnt_r <= WAIT_LOAD;
        we_r       <= we;
        addr_r     <= addr;
        wdata_r    <= wdata;
      end else if ((state_r == ST_WAIT) && (wait_cnt_r != 4'd0)) begin
        wait_cnt_r <= wait_cnt_r - 4'd1;
      end
    end
  end

  // Output registers update on the edge that ends ACK
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < N_OUT; k++) begin
        out_r[k] <= '0;
      end
    end else begin
      for (int k = 0; k < N_OUT; k++) begin
        if (commit_s && out_hit_s && (out_off_s == ADDR_W'(k))) begin
          out_r[k] <= wdata_r;
        end
      end
    end
  end

  // RAM array keeps its contents across reset
  always_ff @(posedge clk) begin
    if (commit_s && ram_hit_s) begin
      mem_r[addr_r] <= wdata_r;
    end
  end

  // Read mux: one-hot OR of the selected port or register
  always_comb begin
    rd_sel_s = '0;
    if (ram_hit_s) begin
      rd_sel_s = mem_r[addr_r];
    end else begin
      for (int k = 0; k < N_IN; k++) begin
        rd_sel_s = rd_sel_s |
                   ((in_hit_s && (in_off_s == ADDR_W'(k))) ? io_in_s[k*DATA_W +: DATA_W] : '0);
      end
      for (int k = 0; k < N_OUT; k++) begin
        rd_sel_s = rd_sel_s |
                   ((out_hit_s && (out_off_s == ADDR_W'(k))) ? out_r[k] : '0);
      end
    end
  end

  assign ack   = (state_r == ST_ACK);
  assign err   = ack && bad_s;
  assign rdata = (ack && !bad_s) ? rd_sel_s : '0;

  for (genvar k = 0; k < N_OUT; k++) begin : g_out_pack
    assign io_out[k*DATA_W +: DATA_W] = out_r[k];
  end

endmodule

// File: tb/tb_mcu_dmem_ctrl.sv
// Randomised and directed bench for mcu_dmem_ctrl against a transaction-level memory-map model.
module tb_mcu_dmem_ctrl;

  localparam int WS = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, we, ack, err;
  logic [7:0]  addr, wdata, rdata;
  logic [15:0] io_in, io_out;
  logic        req0, we0, ack0, err0;
  logic [7:0]  addr0, wdata0, rdata0;
  logic [15:0] io_out0;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [7:0] mem_m   [256];
  bit         known_m [256];
  logic [7:0] out_m   [2];

  always #5 clk = ~clk;

  mcu_dmem_ctrl dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ack(ack), .err(err), .io_in(io_in), .io_out(io_out)
  );

  mcu_dmem_ctrl #(.WAIT_STATES(0)) dut_ws0 (
    .clk(clk), .rst(rst), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
    .rdata(rdata0), .ack(ack0), .err(err0), .io_in(io_in), .io_out(io_out0)
  );

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // One access on the WAIT_STATES=1 instance, checked against the map model
  task automatic do_access(input logic w, input logic [7:0] a, input logic [7:0] d);
    int         cyc;
    logic       bad;
    logic       chk_rd;
    logic [7:0] exp_rd;
    bad    = (a >= 8'hF4) || (w && (a < 8'hF2) && (a >= 8'hF0));
    chk_rd = !w || bad;
    exp_rd = 8'h00;
    if (!bad) begin
      if (a < 8'hF0) begin
        exp_rd = mem_m[a];
        chk_rd = chk_rd && known_m[a];
      end else if (a < 8'hF2) begin
        exp_rd = io_in[int'(a - 8'hF0) * 8 +: 8];
      end else begin
        exp_rd = out_m[int'(a - 8'hF2)];
      end
    end
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = d;
    @(posedge clk); #1;
    cyc = 1;
    req = 1'($urandom); we = 1'($urandom); addr = 8'($urandom); wdata = 8'($urandom);
    while (!ack && cyc < 16) begin
      @(posedge clk); #1;
      cyc++;
    end
    req = 1'b0;
    check_val("latency", cyc, WS + 1);
    check_val("err", err, bad);
    if (chk_rd) check_val("rdata", rdata, exp_rd);
    @(posedge clk); #1;
    check_val("ack_pulse", ack, 1'b0);
    check_val("idle_err", err, 1'b0);
    check_val("idle_rdata", rdata, 8'h00);
    if (w && !bad) begin
      if (a < 8'hF0) begin
        mem_m[a]   = d;
        known_m[a] = 1'b1;
      end else begin
        out_m[int'(a - 8'hF2)] = d;
      end
    end
    check_val("io_out", io_out, {out_m[1], out_m[0]});
  endtask

  initial begin
    req = 1'b0; we = 1'b0; addr = 8'h00; wdata = 8'h00; io_in = 16'h0000;
    req0 = 1'b0; we0 = 1'b0; addr0 = 8'h00; wdata0 = 8'h00;
    out_m[0] = 8'h00; out_m[1] = 8'h00;
    for (int i = 0; i < 256; i++) begin
      known_m[i] = 1'b0;
      mem_m[i]   = 8'h00;
    end
    rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    check_val("rst_ack", ack, 1'b0);
    check_val("rst_err", err, 1'b0);
    check_val("rst_rdata", rdata, 8'h00);
    check_val("rst_io_out", io_out, 16'h0000);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // RAM write / read-back
    do_access(1'b1, 8'h10, 8'h5A);
    do_access(1'b0, 8'h10, 8'h00);
    // Output register write / read-back
    do_access(1'b1, 8'hF3, 8'hC3);
    check_val("io_out_hi", io_out[15:8], 8'hC3);
    do_access(1'b0, 8'hF3, 8'h00);
    // Input ports
    io_in = 16'hBEEF;
    do_access(1'b0, 8'hF0, 8'h00);
    do_access(1'b0, 8'hF1, 8'h00);
    // Error accesses leave state untouched
    do_access(1'b1, 8'hF1, 8'h99);
    do_access(1'b0, 8'hF8, 8'h00);
    do_access(1'b1, 8'hFF, 8'h99);
    do_access(1'b0, 8'h10, 8'h00);

    // Reset during WAIT aborts the write
    do_access(1'b1, 8'h20, 8'h11);
    do_access(1'b1, 8'hF2, 8'h66);
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 8'h20; wdata = 8'h77;
    @(posedge clk); #1;
    req = 1'b0;
    #2 rst = 1'b0;
    #1;
    check_val("abort_ack", ack, 1'b0);
    check_val("abort_io_out", io_out, 16'h0000);
    repeat (3) begin
      @(posedge clk); #1;
      check_val("abort_ack_hold", ack, 1'b0);
    end
    out_m[0] = 8'h00; out_m[1] = 8'h00;
    @(posedge clk); #1;
    rst = 1'b1;
    do_access(1'b0, 8'h20, 8'h00);
    do_access(1'b0, 8'hF2, 8'h00);

    // Randomised traffic
    for (int n = 0; n < 150; n++) begin
      logic [7:0] a;
      io_in = 16'($urandom);
      if ($urandom_range(1, 0) == 1) a = 8'($urandom_range(31, 0));
      else                           a = 8'hF0 + 8'($urandom_range(15, 0));
      do_access(1'($urandom), a, 8'($urandom));
    end

    // Zero-wait instance: req held high gives ack every other cycle
    io_in = 16'h1234;
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'hF1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check_val("ws0_ack", ack0, (i % 2) == 0);
      if (ack0) check_val("ws0_rdata", rdata0, 8'h12);
      else      check_val("ws0_idle_rdata", rdata0, 8'h00);
    end
    @(negedge clk);
    req0 = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b1; addr0 = 8'hF2; wdata0 = 8'hA5;
    @(posedge clk); #1;
    req0 = 1'b0;
    check_val("ws0_wr_ack", ack0, 1'b1);
    check_val("ws0_wr_err", err0, 1'b0);
    @(posedge clk); #1;
    check_val("ws0_io_out", io_out0[7:0], 8'hA5);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
